// File: rtl/atr_cmd_pkg.sv
// rtl/atr_cmd_pkg.sv - shared opcodes, sync byte and FSM encodings for the command link (CMD_CHECKSUM_EN adds P_CHK)
package atr_cmd_pkg;

  localparam logic [7:0] OP_START      = 8'h01;
  localparam logic [7:0] OP_SET_CYCLES = 8'h02;
  localparam logic [7:0] OP_ABORT      = 8'h03;
  localparam logic [7:0] OP_QUERY      = 8'h04;
  localparam logic [7:0] SYNC_BYTE     = 8'hA5;

  typedef enum logic [1:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP
  } bit_state_t;

  typedef enum logic [2:0] {
    P_WAIT_SYNC,
    P_OP,
    P_ARG_HI,
    P_ARG_LO,
`ifdef CMD_CHECKSUM_EN
    P_CHK,
`endif
    P_EMIT
  } parser_state_t;

  function automatic logic op_is_valid(input logic [7:0] op);
    return (op >= OP_START) && (op <= OP_QUERY);
  endfunction

endpackage

// File: rtl/uart_cmd_rx_if.sv
// rtl/uart_cmd_rx_if.sv - command valid/ready handshake between the UART parser and the sweep FSM
interface uart_cmd_rx_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_op;
  logic [15:0] cmd_arg;

  modport master (output cmd_valid, output cmd_op, output cmd_arg, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_arg, output cmd_ready);
endinterface

// File: rtl/uart_rx_byte.sv
// rtl/uart_rx_byte.sv - 8N1 byte receiver: rx synchroniser, 16x oversample tick generator and bit FSM
module uart_rx_byte
  import atr_cmd_pkg::*;
#(
  parameter int CLK_HZ = 100_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       normal_clk,
  input  logic       reset,
  input  logic       rx,
  output logic       tick,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       stop_err
);

  localparam int DIV   = CLK_HZ / (BAUD * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic             rx_meta, rx_sync, rx_prev, rx_fall;
  logic [DIV_W-1:0] div_cnt;
  bit_state_t       state, state_nxt;
  logic [3:0]       os_cnt, os_nxt;
  logic [2:0]       bit_idx, idx_nxt;
  logic [7:0]       shreg, sh_nxt;
  logic             valid_nxt, serr_nxt, start_det;

  // Preset high so a reset does not look like a start edge.
  always_ff @(posedge normal_clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev & ~rx_sync;
  assign tick    = (div_cnt == DIV_W'(DIV - 1));

  always_ff @(posedge normal_clk) begin
    if (reset || start_det || tick) div_cnt <= '0;
    else                            div_cnt <= div_cnt + DIV_W'(1);
  end

  always_ff @(posedge normal_clk) begin
    if (reset) begin
      state      <= B_IDLE;
      os_cnt     <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      stop_err   <= 1'b0;
    end else begin
      state      <= state_nxt;
      os_cnt     <= os_nxt;
      bit_idx    <= idx_nxt;
      shreg      <= sh_nxt;
      byte_valid <= valid_nxt;
      stop_err   <= serr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    os_nxt    = os_cnt;
    idx_nxt   = bit_idx;
    sh_nxt    = shreg;
    valid_nxt = 1'b0;
    serr_nxt  = 1'b0;
    start_det = 1'b0;
    case (state)
      B_IDLE: begin
        if (rx_fall) begin
          start_det = 1'b1;
          os_nxt    = '0;
          state_nxt = B_START;
        end
      end
      B_START: begin
        if (tick) begin
          if (os_cnt == 4'd7) begin
            os_nxt    = '0;
            idx_nxt   = '0;
            state_nxt = rx_sync ? B_IDLE : B_DATA;
          end else begin
            os_nxt = os_cnt + 4'd1;
          end
        end
      end
      B_DATA: begin
        if (tick) begin
          os_nxt = os_cnt + 4'd1;
          if (os_cnt == 4'd15) begin
            sh_nxt = {rx_sync, shreg[7:1]};
            if (bit_idx == 3'd7) state_nxt = B_STOP;
            else                 idx_nxt   = bit_idx + 3'd1;
          end
        end
      end
      B_STOP: begin
        if (tick) begin
          os_nxt = os_cnt + 4'd1;
          if (os_cnt == 4'd15) begin
            valid_nxt = rx_sync;
            serr_nxt  = ~rx_sync;
            state_nxt = B_IDLE;
          end
        end
      end
      default: state_nxt = B_IDLE;
    endcase
  end

  assign byte_data = shreg;

endmodule

// File: rtl/uart_cmd_rx.sv
// rtl/uart_cmd_rx.sv - UART command frame parser with valid/ready output; CMD_CHECKSUM_EN adds an XOR checksum byte
module uart_cmd_rx
  import atr_cmd_pkg::*;
#(
  parameter int CLK_HZ        = 100_000_000,
  parameter int BAUD          = 115200,
  parameter int TIMEOUT_TICKS = 4096
) (
  input  logic           normal_clk,
  input  logic           reset,
  input  logic           rx,
  uart_cmd_rx_if.master  cmd,
  output logic           frame_err,
  output logic           overrun,
  output logic [7:0]     err_count
);

  localparam int GAP_W = $clog2(TIMEOUT_TICKS + 1);

  logic             tick, byte_valid, stop_err, timeout;
  logic [7:0]       byte_data;
  logic [GAP_W-1:0] gap_cnt;

  parser_state_t p_state, p_nxt;
  logic [7:0]    op_reg, op_nxt, hi_reg, hi_nxt, lo_reg, lo_nxt;
  logic          cmd_valid_r, v_nxt;
  logic [7:0]    cmd_op_r, cop_nxt;
  logic [15:0]   cmd_arg_r, carg_nxt;
  logic          err_nxt, ovr_nxt;

  uart_rx_byte #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) u_rx_byte (
    .normal_clk (normal_clk),
    .reset      (reset),
    .rx         (rx),
    .tick       (tick),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .stop_err   (stop_err)
  );

  // Idle gap between delivered bytes, saturating at the timeout.
  always_ff @(posedge normal_clk) begin
    if (reset || byte_valid)
      gap_cnt <= '0;
    else if (tick && gap_cnt != GAP_W'(TIMEOUT_TICKS))
      gap_cnt <= gap_cnt + GAP_W'(1);
  end

  assign timeout = (gap_cnt == GAP_W'(TIMEOUT_TICKS)) &&
                   (p_state != P_WAIT_SYNC) && (p_state != P_EMIT);

  always_ff @(posedge normal_clk) begin
    if (reset) begin
      p_state     <= P_WAIT_SYNC;
      op_reg      <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
      cmd_valid_r <= 1'b0;
      cmd_op_r    <= '0;
      cmd_arg_r   <= '0;
      frame_err   <= 1'b0;
      overrun     <= 1'b0;
      err_count   <= '0;
    end else begin
      p_state     <= p_nxt;
      op_reg      <= op_nxt;
      hi_reg      <= hi_nxt;
      lo_reg      <= lo_nxt;
      cmd_valid_r <= v_nxt;
      cmd_op_r    <= cop_nxt;
      cmd_arg_r   <= carg_nxt;
      frame_err   <= err_nxt;
      overrun     <= ovr_nxt;
      if (err_nxt && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

  always_comb begin
    p_nxt    = p_state;
    op_nxt   = op_reg;
    hi_nxt   = hi_reg;
    lo_nxt   = lo_reg;
    v_nxt    = cmd_valid_r;
    cop_nxt  = cmd_op_r;
    carg_nxt = cmd_arg_r;
    err_nxt  = 1'b0;
    ovr_nxt  = 1'b0;
    if (cmd_valid_r && cmd.cmd_ready) v_nxt = 1'b0;
    case (p_state)
      P_WAIT_SYNC: begin
        if (byte_valid && byte_data == SYNC_BYTE) p_nxt = P_OP;
      end
      P_OP: begin
        if (byte_valid) begin
          if (op_is_valid(byte_data)) begin
            op_nxt = byte_data;
            p_nxt  = P_ARG_HI;
          end else begin
            err_nxt = 1'b1;
            p_nxt   = P_WAIT_SYNC;
          end
        end
      end
      P_ARG_HI: begin
        if (byte_valid) begin
          hi_nxt = byte_data;
          p_nxt  = P_ARG_LO;
        end
      end
      P_ARG_LO: begin
        if (byte_valid) begin
          lo_nxt = byte_data;
`ifdef CMD_CHECKSUM_EN
          p_nxt  = P_CHK;
`else
          p_nxt  = P_EMIT;
`endif
        end
      end
`ifdef CMD_CHECKSUM_EN
      P_CHK: begin
        if (byte_valid) begin
          if (byte_data == (op_reg ^ hi_reg ^ lo_reg)) begin
            p_nxt = P_EMIT;
          end else begin
            err_nxt = 1'b1;
            p_nxt   = P_WAIT_SYNC;
          end
        end
      end
`endif
      P_EMIT: begin
        p_nxt = P_WAIT_SYNC;
        // A handshake this cycle frees the holding register for the new command.
        if (cmd_valid_r && !cmd.cmd_ready) begin
          ovr_nxt = 1'b1;
        end else begin
          v_nxt    = 1'b1;
          cop_nxt  = op_reg;
          carg_nxt = {hi_reg, lo_reg};
        end
      end
      default: p_nxt = P_WAIT_SYNC;
    endcase
    if (stop_err && p_state != P_EMIT) begin
      err_nxt = 1'b1;
      p_nxt   = P_WAIT_SYNC;
    end else if (timeout && !byte_valid) begin
      err_nxt = 1'b1;
      p_nxt   = P_WAIT_SYNC;
    end
  end

  assign cmd.cmd_valid = cmd_valid_r;
  assign cmd.cmd_op    = cmd_op_r;
  assign cmd.cmd_arg   = cmd_arg_r;

endmodule
